// File: rtl/clk_div_meas.sv
// clk_div_meas: measures high/low/period of an asynchronous monitored clock in clk_i cycles,
// with period-lock detection and stall detection on a saturated level counter.
module clk_div_meas #(
    parameter int CNT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 en_i,
    input  logic                 mon_clk_i,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic [CNT_WIDTH-1:0] low_o,
    output logic [CNT_WIDTH:0]   period_o,
    output logic                 valid_o,
    output logic                 locked_o,
    output logic                 stall_o
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    typedef enum logic [2:0] {IDLE, ARM, SYNC, HIGH, LOW} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic [CNT_WIDTH-1:0]   cnt_q, high_cap_q;
    logic [CNT_WIDTH:0]     prev_q, period_d;
    logic [MW-1:0]          match_q, match_d;
    logic                   have_prev_q;
    logic                   s, rise, fall, edge_hit, sat;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_q;
    assign fall     = ~s & s_q;
    assign edge_hit = (state_q == HIGH) ? fall : rise;
    assign sat      = cnt_q == CNT_MAX;
    assign period_d = {1'b0, high_cap_q} + {1'b0, cnt_q};

    // The first measurement after ARM has nothing to compare against.
    always_comb begin
        match_d = !have_prev_q          ? '0 :
                  (period_d != prev_q)  ? '0 :
                  (match_q == LOCK_N)   ? match_q : match_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            s_q         <= 1'b0;
            cnt_q       <= '0;
            high_cap_q  <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            high_o      <= '0;
            low_o       <= '0;
            period_o    <= '0;
            valid_o     <= 1'b0;
            locked_o    <= 1'b0;
            stall_o     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
            s_q     <= s;
            valid_o <= 1'b0;
            if (!en_i) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                match_q  <= '0;
                locked_o <= 1'b0;
                stall_o  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q     <= ARM;
                        have_prev_q <= 1'b0;
                    end
                    ARM: if (fall) state_q <= SYNC;
                    SYNC: if (rise) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= HIGH;
                    end
                    HIGH, LOW: begin
                        if (edge_hit && state_q == HIGH) begin
                            high_cap_q <= cnt_q;
                            cnt_q      <= CNT_ONE;
                            state_q    <= LOW;
                        end else if (edge_hit) begin
                            high_o      <= high_cap_q;
                            low_o       <= cnt_q;
                            period_o    <= period_d;
                            valid_o     <= 1'b1;
                            stall_o     <= 1'b0;
                            prev_q      <= period_d;
                            have_prev_q <= 1'b1;
                            match_q     <= match_d;
                            locked_o    <= match_d == LOCK_N;
                            cnt_q       <= CNT_ONE;
                            state_q     <= HIGH;
                        end else if (sat) begin
                            stall_o     <= 1'b1;
                            locked_o    <= 1'b0;
                            match_q     <= '0;
                            have_prev_q <= 1'b0;
                            state_q     <= ARM;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clk_div_meas.sv
// tb_clk_div_meas: directed checks of clk_div_meas measurement, lock, stall, enable and reset.
module tb_clk_div_meas;
    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       en = 1'b0;
    logic       mon = 1'b0;
    logic [7:0] high, low;
    logic [8:0] period;
    logic       valid, locked, stall;

    int  n_tests = 0;
    int  n_fail = 0;
    int  hi_len = 3, lo_len = 3, ph_cnt = 0;
    logic gen_on = 1'b0, hold_val = 1'b0;

    clk_div_meas #(.CNT_WIDTH(8), .SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
        .clk_i(clk), .arst_ni(arst_n), .en_i(en), .mon_clk_i(mon),
        .high_o(high), .low_o(low), .period_o(period),
        .valid_o(valid), .locked_o(locked), .stall_o(stall)
    );

    always #5 clk = ~clk;

    // Monitored clock: each level lasts exactly hi_len / lo_len clk cycles.
    always begin
        @(posedge clk); #1;
        if (!gen_on) begin
            mon = hold_val;
            ph_cnt = 0;
        end else begin
            if (ph_cnt == 0) begin
                mon = ~mon;
                ph_cnt = mon ? hi_len : lo_len;
            end
            ph_cnt = ph_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_valid(input int maxc, output int waited);
        waited = 0;
        do begin step(); waited++; end while (!valid && waited < maxc);
        chk("valid_seen", 32'(valid), 1);
    endtask

    task automatic wait_mon(input logic lvl);
        int n = 0;
        while (mon !== lvl && n < 20) begin step(); n++; end
        chk("mon_level", 32'(mon), 32'(lvl));
    endtask

    initial begin
        int w, n;
        logic seen_valid, prev;
        // reset state
        repeat (3) step();
        chk("rst_high", 32'(high), 0);
        chk("rst_low", 32'(low), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_stall", 32'(stall), 0);
        // 3/3 toggling, lock on 5th valid
        arst_n = 1'b1; en = 1'b1; gen_on = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_valid(40, w);
            if (i == 1) begin
                chk("sym_high", 32'(high), 3);
                chk("sym_low", 32'(low), 3);
                chk("sym_period", 32'(period), 6);
            end
            if (i == 3) chk("sym_spacing", w, 6);
            if (i == 4) chk("sym_lock4", 32'(locked), 0);
            if (i == 5) chk("sym_lock5", 32'(locked), 1);
        end
        step();
        chk("valid_pulse", 32'(valid), 0);
        // period change 6 -> 10
        wait_mon(1'b0);
        hi_len = 5; lo_len = 5;
        n = 0;
        do begin wait_valid(30, w); n++; end while (period == 6 && n < 4);
        chk("chg_period", 32'(period), 10);
        chk("chg_high", 32'(high), 5);
        chk("chg_unlock", 32'(locked), 0);
        for (int i = 1; i <= 4; i++) begin
            wait_valid(30, w);
            if (i == 3) chk("chg_lock3", 32'(locked), 0);
            if (i == 4) begin
                chk("chg_lock4", 32'(locked), 1);
                chk("chg_spacing", w, 10);
            end
        end
        // asymmetric 2 high / 5 low
        wait_mon(1'b0);
        hi_len = 2; lo_len = 5;
        n = 0;
        do begin wait_valid(30, w); n++; end while (period == 10 && n < 4);
        chk("asym_high", 32'(high), 2);
        chk("asym_low", 32'(low), 5);
        chk("asym_period", 32'(period), 7);
        chk("asym_unlock", 32'(locked), 0);
        wait_valid(30, w);
        chk("asym_spacing", w, 7);
        chk("asym_period2", 32'(period), 7);
        // stuck high -> stall after 255 cycles
        hold_val = 1'b1; gen_on = 1'b0;
        wait_valid(20, w);
        n = 0; seen_valid = 1'b0;
        do begin step(); n++; seen_valid |= valid; end while (!stall && n < 300);
        chk("stall_cycles", n, 255);
        chk("stall_locked", 32'(locked), 0);
        chk("stall_no_valid", 32'(seen_valid), 0);
        // restart toggling; stall sticky until next valid
        hi_len = 3; lo_len = 3; gen_on = 1'b1;
        repeat (5) step();
        chk("stall_sticky", 32'(stall), 1);
        wait_valid(40, w);
        chk("restart_stall", 32'(stall), 0);
        chk("restart_period", 32'(period), 6);
        for (int i = 0; i < 4; i++) wait_valid(30, w);
        chk("relock", 32'(locked), 1);
        // en_i low for one cycle mid-HIGH
        en = 1'b0;
        step();
        en = 1'b1;
        chk("dis_valid", 32'(valid), 0);
        chk("dis_locked", 32'(locked), 0);
        chk("dis_stall", 32'(stall), 0);
        chk("dis_high_hold", 32'(high), 3);
        chk("dis_low_hold", 32'(low), 3);
        chk("dis_period_hold", 32'(period), 6);
        wait_valid(40, w);
        chk("reen_latency", 32'(w >= 7), 1);
        chk("reen_high", 32'(high), 3);
        chk("reen_low", 32'(low), 3);
        // reset pulse while mon has just risen and the DUT is still in LOW
        n = 0; prev = mon;
        do begin prev = mon; step(); n++; end while (!(mon && !prev) && n < 20);
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        chk("rst2_high", 32'(high), 0);
        chk("rst2_low", 32'(low), 0);
        chk("rst2_period", 32'(period), 0);
        chk("rst2_valid", 32'(valid), 0);
        chk("rst2_locked", 32'(locked), 0);
        chk("rst2_stall", 32'(stall), 0);
        wait_valid(40, w);
        chk("rst2_latency", 32'(w >= 9), 1);
        chk("rst2_meas_high", 32'(high), 3);
        chk("rst2_meas_low", 32'(low), 3);
        chk("rst2_meas_lock", 32'(locked), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_meas.md
Name: clk_div_meas

Overview:
- Receive-side companion to the clock divider: measures a divided clock (mon_clk_i) in units of the fast system clock clk_i.
- Reports high time, low time and period in clk_i cycles, and flags lock once the ratio is stable.
- Flags a stall when the monitored clock stops.
- Used for divider self-check, ratio discovery on incoming slow clocks, and clock-health monitoring.

Parameters:
- CNT_WIDTH, 8, width of the per-level cycle counter; the maximum measurable level length is 2^CNT_WIDTH-1.
- SYNC_STAGES, 2, number of synchronizer flops on mon_clk_i; minimum 2.
- LOCK_COUNT, 4, number of consecutive equal-period matches required to assert locked_o.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- arst_ni  input  1  active-low reset, synchronous: sampled on the rising edge of clk_i.
- en_i  input  1  measurement enable.
- mon_clk_i  input  1  monitored (divided) clock; treated as asynchronous.
- high_o  output  CNT_WIDTH  last measured high time, in clk_i cycles.
- low_o  output  CNT_WIDTH  last measured low time, in clk_i cycles.
- period_o  output  CNT_WIDTH+1  high_o + low_o of the last measurement.
- valid_o  output  1  one-cycle pulse when high_o, low_o and period_o update.
- locked_o  output  1  period stable for LOCK_COUNT consecutive matches.
- stall_o  output  1  monitored clock stopped (level counter saturated).

Behaviour:
- Reset: arst_ni=0 at a clk_i edge forces the following, regardless of en_i:
  - state=IDLE; synchronizer chain, s_q, cnt and match_cnt all 0.
  - high_o, low_o, period_o, valid_o, locked_o and stall_o all 0.
- Synchronizer and edge detect:
  - mon_clk_i passes through SYNC_STAGES flops; the last stage is s, and s_q is s delayed by one cycle.
  - rise = s & ~s_q; fall = ~s & s_q.
  - An input edge is detected SYNC_STAGES cycles after the clk_i edge that samples it.
  - Levels shorter than one clk_i period may be missed; no requirement applies to them.
- FSM states: IDLE, ARM, SYNC, HIGH, LOW.
  - IDLE: next state is ARM when en_i=1.
  - ARM (waits for fall): next state is SYNC on fall. This discards any partial high level seen at enable or after reset.
  - SYNC: on rise, cnt<=1 and next state is HIGH.
  - HIGH, no edge: cnt<=cnt+1.
  - HIGH, on fall: high_cap<=cnt, cnt<=1, next state is LOW.
  - LOW, no edge: cnt<=cnt+1.
  - LOW, on rise:
    - high_o<=high_cap; low_o<=cnt; period_o<=high_cap+cnt, computed at CNT_WIDTH+1 bits with no overflow.
    - valid_o<=1 for one cycle; cnt<=1; next state is HIGH.
    - stall_o<=0.
  - Result: a level lasting N synchronized cycles is reported as N. Outputs change on the cycle after the rise is detected.
- Saturation: in HIGH or LOW, if cnt = 2^CNT_WIDTH-1 and no edge is present:
  - stall_o<=1, locked_o<=0, match_cnt<=0, next state is ARM.
  - stall_o is sticky until the next valid_o or until en_i=0.
- Lock:
  - prev_period is stored on every valid_o.
  - On each valid_o after the first since ARM: equal to prev_period means match_cnt++ (saturating at LOCK_COUNT); unequal means match_cnt<=0.
  - locked_o = (match_cnt == LOCK_COUNT), registered. It asserts on the same cycle as the (LOCK_COUNT+1)-th equal valid_o.
  - A mismatching valid_o drops locked_o on that same cycle.
  - The first valid_o after ARM never counts as a match.
- en_i=0 in any state:
  - Next cycle: state=IDLE; cnt and match_cnt cleared; valid_o, locked_o and stall_o = 0.
  - high_o, low_o and period_o hold their last values.
- Simultaneous events:
  - Reset beats en_i.
  - en_i=0 beats an edge or saturation in the same cycle: no valid_o is issued.
  - An edge in the same cycle cnt is at maximum counts as an edge: the capture is the max value and there is no stall.
- valid_o never asserts in IDLE, ARM or SYNC.

Test Plan:
- mon_clk_i toggles every 3 clk_i cycles, en_i=1 -> high_o=3, low_o=3, period_o=6; valid_o every 6 cycles; locked_o=1 with the 5th valid_o.
- Asymmetric mon_clk_i, 2 cycles high and 5 cycles low -> high_o=2, low_o=5, period_o=7, valid_o every 7 cycles.
- Change from locked period 6 to period 10 (5 high, 5 low):
  - The first valid_o with period_o=10 drops locked_o in the same cycle.
  - locked_o reasserts 4 matching valid_o pulses later.
- mon_clk_i stuck high, CNT_WIDTH=8:
  - 255 cycles after the rise, stall_o=1 and locked_o=0, with no valid_o.
  - Restart toggling -> stall_o=0 at the next valid_o.
- en_i=0 for 1 cycle mid-HIGH:
  - Next cycle valid_o, locked_o and stall_o = 0; high_o, low_o and period_o unchanged.
  - After re-enable, the first valid_o requires fall -> rise -> fall -> rise.
- arst_ni=0 for 1 cycle while mon_clk_i is high, mid-LOW:
  - All outputs read 0 on the cycle after reset.
  - The spurious post-reset rise produces no valid_o.
  - The first valid_o follows the ARM fall plus one full period.
